// File: rtl/drum_audio_out_pkg.sv
// Shared defaults for the drum-mesh audio output path.
// Amplitudes are signed two's complement Q1.(DATA_W-1) fractions, the same format as alpha/delta.
package drum_audio_out_pkg;
   localparam int          DATA_W_DEF  = 32;
   localparam int          AUDIO_W_DEF = 16;
   localparam logic [15:0] AUDIO_MAX   = 16'h7FFF;
   localparam logic [15:0] AUDIO_MIN   = 16'h8000;
endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO with async active-low reset.
module audio_sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             wr, rd;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign wr      = push_i & (~full_o | pop_i);
   assign rd      = pop_i & ~empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({wr, rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/drum_audio_out.sv
// Captures the centre-node amplitude once per solver step, scales/saturates it to audio
// width and buffers it for the codec over a valid/ready handshake.
module drum_audio_out
   import drum_audio_out_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int AUDIO_W    = AUDIO_W_DEF,
   parameter int GAIN_SHIFT = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic signed [DATA_W-1:0]      u_center,
   input  logic                          step_done,
   input  logic                          audio_ready,
   input  logic                          clear_ovf,
   output logic signed [AUDIO_W-1:0]     audio_data,
   output logic                          audio_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [31:0]                   sample_cnt
);
   localparam int WW = DATA_W + GAIN_SHIFT;

   function automatic logic signed [AUDIO_W-1:0] scale_sat(input logic signed [DATA_W-1:0] u);
      logic signed [WW-1:0]     wide;
      logic [GAIN_SHIFT:0]      top;
      logic signed [DATA_W-1:0] s;
      wide = WW'(u) <<< GAIN_SHIFT;
      top  = wide[WW-1:DATA_W-1];
      if ((&top) || !(|top)) s = wide[DATA_W-1:0];
      else if (u[DATA_W-1])  s = {1'b1, {(DATA_W-1){1'b0}}};
      else                   s = {1'b0, {(DATA_W-1){1'b1}}};
      return s[DATA_W-1 -: AUDIO_W];
   endfunction

   logic                      step_prev_q;
   logic                      vld_p1_q, vld_p2_q;
   logic signed [DATA_W-1:0]  u_p1_q;
   logic signed [AUDIO_W-1:0] sample_p2_q;
   logic                      overflow_q, overflow_d;
   logic [31:0]               sample_cnt_q, sample_cnt_d;
   logic                      capture, pop, push_ok, full, empty;
   logic [AUDIO_W-1:0]        fifo_head;

   assign capture = step_done & ~step_prev_q;
   assign pop     = audio_valid & audio_ready;
   assign push_ok = vld_p2_q & (~full | pop);

   always_comb begin
      sample_cnt_d = sample_cnt_q + 32'(push_ok);
      overflow_d   = overflow_q;
      if (clear_ovf) overflow_d = 1'b0;
      if (vld_p2_q && full && !pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_prev_q  <= 1'b0;
         vld_p1_q     <= 1'b0;
         vld_p2_q     <= 1'b0;
         overflow_q   <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         step_prev_q  <= step_done;
         vld_p1_q     <= capture;
         vld_p2_q     <= vld_p1_q;
         overflow_q   <= overflow_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   // Stage 1: capture amplitude; stage 2: scale and saturate
   always_ff @(posedge clk) begin
      if (capture) u_p1_q <= u_center;
      sample_p2_q <= scale_sat(u_p1_q);
   end

   // Stage 3: buffer for the codec
   audio_sample_fifo #(
      .WIDTH (AUDIO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (vld_p2_q),
      .pop_i   (audio_ready),
      .data_i  (sample_p2_q),
      .data_o  (fifo_head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

   assign audio_data  = fifo_head;
   assign audio_valid = ~empty;
   assign overflow    = overflow_q;
   assign sample_cnt  = sample_cnt_q;
endmodule
